data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter and sequencer for the MIPS64 data memory. It shares the single-ported, synchronous-read data RAM between the CPU MEM stage (port 0) and the program/debug loader (port 1). It issues one memory operation at a time over a registered req/ack handshake, alternates between the ports with round-robin arbitration, and rejects out-of-range addresses without touching the RAM.

## Interface
Parameters:
- DATA_BITS, 64, data word width
- ADDR_BITS, 64, requester address width
- MEM_ADDR_BITS, 10, implemented RAM word-address width; valid addresses are 0 .. 2**MEM_ADDR_BITS-1

Ports:
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- p0_req / p1_req  in  1  access request; held until ack
- p0_we / p1_we  in  1  1 = write, 0 = read; stable while req high
- p0_addr / p1_addr  in  ADDR_BITS  word address; stable while req high
- p0_wdata / p1_wdata  in  DATA_BITS  write data; stable while req high
- p0_ack / p1_ack  out  1  one-cycle completion pulse
- p0_err / p1_err  out  1  qualifies ack: address out of range
- p0_rdata / p1_rdata  out  DATA_BITS  read data, valid only while ack=1
- p0_stall  out  1  p0_req & ~p0_ack; freezes the CPU pipeline
- mem_en  out  1  RAM enable, registered
- mem_wr  out  1  RAM write, registered
- mem_addr  out  ADDR_BITS  RAM address, registered
- mem_wdata  out  DATA_BITS  RAM write data, registered
- mem_rdata  in  DATA_BITS  RAM registered output; on a write it echoes the written data

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Request(s) present: pick a winner, latch its we/addr/wdata into the mem_* registers and into a winner register, then go to ISSUE.
  - mem_en is set to 1 only when the address is in range. An out-of-range address sets err_q=1 instead.
- Arbitration:
  - Round-robin over a 1-bit last_grant register.
  - Both ports requesting: the port not equal to last_grant wins.
  - One port requesting: that port wins.
  - last_grant is updated to the winner on every grant, including error grants.
- ISSUE: the RAM samples mem_* at the end of this cycle. Then clear mem_en and mem_wr and go to RESP.
- RESP:
  - Assert ack of the winner for exactly one cycle.
  - err = err_q.
  - rdata = mem_rdata, or 0 when err_q=1.
  - The non-winner's ack, err and rdata are 0.
  - Next state is always IDLE. There is no back-to-back grant from RESP.
- A write returns its written data on rdata, via the RAM echo.
- Range check: the address is in range iff addr[ADDR_BITS-1:MEM_ADDR_BITS] == 0. mem_addr carries the full address, zero-extended as received.
- A port must not drop req before its ack. If it does, the access already latched still completes and the ack pulse is still issued.
- Reset values, asserted asynchronously on rst_n low:
  - state=IDLE, last_grant=1 (port 0 favoured first), err_q=0.
  - mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - All ack, err and rdata outputs = 0.
- Reset mid-access abandons the access immediately. No ack is issued, and mem_en drops without waiting for clk.

## Timing
- Request sampled at edge E0 (state IDLE). ISSUE runs E0→E1 with mem_en=1. RESP runs E1→E2 with ack=1. Back in IDLE after E2.
- The requester deasserts req or presents a new request after E2. A req still high at E3 is taken as a new access.
- Latency: req visible → ack is 2 cycles. Throughput: 1 access per 3 cycles.
- Contended request: worst-case wait is one full foreign access (3 cycles) plus its own 3 cycles.
- mem_en and mem_wr are high for exactly one cycle per in-range access and never high outside ISSUE.
- p0_stall is combinational and drops in the same cycle p0_ack rises.

## Test plan
- Single read, port 0:
  - Stimulus: preload RAM[5]=64'hDEAD_BEEF_0000_0005, p0 reads addr 5.
  - Required: mem_en=1 for one cycle at addr 5, mem_wr=0; p0_ack 2 cycles after req with p0_rdata=64'hDEAD_BEEF_0000_0005 and p0_err=0; p0_stall high for exactly 2 cycles.
- Write then read, port 1:
  - Stimulus: p1 writes 64'h1234 to addr 10; after its ack, p1 reads addr 10.
  - Required: the write ack carries rdata=64'h1234, the read returns 64'h1234, and mem_wr pulses once.
- Simultaneous requests out of reset:
  - Stimulus: p0 and p1 request together and keep re-requesting.
  - Required: grants alternate p0, p1, p0, p1; each ack is 3 cycles after the previous one; no cycle has both acks high.
- Out of range:
  - Stimulus: p0 reads addr 2**MEM_ADDR_BITS (1024).
  - Required: mem_en stays 0; p0_ack=1 with p0_err=1 and p0_rdata=0; last_grant advances to 0 (a following contended request goes to p1).
- Reset mid-access:
  - Stimulus: rst_n low during ISSUE of a p1 write.
  - Required: mem_en and mem_wr are 0 immediately and no p1_ack is issued; after release, a p0 read of addr 3 completes normally within 2 cycles of its req.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the RAM.
// The arbiter takes the slave view; the requesters/RAM side takes the master view.
interface data_mem_arbiter_if #(
    parameter int DATA_BITS = 64,
    parameter int ADDR_BITS = 64
);
    logic                 p0_req;
    logic                 p0_we;
    logic [ADDR_BITS-1:0] p0_addr;
    logic [DATA_BITS-1:0] p0_wdata;
    logic                 p0_ack;
    logic                 p0_err;
    logic [DATA_BITS-1:0] p0_rdata;
    logic                 p0_stall;

    logic                 p1_req;
    logic                 p1_we;
    logic [ADDR_BITS-1:0] p1_addr;
    logic [DATA_BITS-1:0] p1_wdata;
    logic                 p1_ack;
    logic                 p1_err;
    logic [DATA_BITS-1:0] p1_rdata;

    logic                 mem_en;
    logic                 mem_wr;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_wdata;
    logic [DATA_BITS-1:0] mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        input  mem_rdata,
        output p0_ack, p0_err, p0_rdata, p0_stall,
        output p1_ack, p1_err, p1_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        output mem_rdata,
        input  p0_ack, p0_err, p0_rdata, p0_stall,
        input  p1_ack, p1_err, p1_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one synchronous-read data RAM between the
// CPU MEM stage (port 0) and the loader (port 1); one access per IDLE-ISSUE-RESP pass.
module data_mem_arbiter #(
    parameter int DATA_BITS     = 64,
    parameter int ADDR_BITS     = 64,
    parameter int MEM_ADDR_BITS = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    data_mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t               state_q;
    logic                 lastGrant_q;
    logic                 winner_q;
    logic                 err_q;
    logic                 p0Ack_q;
    logic                 p1Ack_q;
    logic                 memEn_q;
    logic                 memWr_q;
    logic [ADDR_BITS-1:0] memAddr_q;
    logic [DATA_BITS-1:0] memWdata_q;

    logic                 winner_d;
    logic                 selWe_d;
    logic [ADDR_BITS-1:0] selAddr_d;
    logic [DATA_BITS-1:0] selWdata_d;
    logic                 inRange_d;

    // Under contention the port that did not win last time is served.
    always_comb begin
        winner_d = bus.p1_req;
        if (bus.p0_req && bus.p1_req) begin
            winner_d = ~lastGrant_q;
        end
        selWe_d    = winner_d ? bus.p1_we    : bus.p0_we;
        selAddr_d  = winner_d ? bus.p1_addr  : bus.p0_addr;
        selWdata_d = winner_d ? bus.p1_wdata : bus.p0_wdata;
        inRange_d  = (selAddr_d[ADDR_BITS-1:MEM_ADDR_BITS] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            winner_q    <= 1'b0;
            err_q       <= 1'b0;
            p0Ack_q     <= 1'b0;
            p1Ack_q     <= 1'b0;
            memEn_q     <= 1'b0;
            memWr_q     <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.p0_req || bus.p1_req) begin
                        winner_q    <= winner_d;
                        lastGrant_q <= winner_d;
                        memEn_q     <= inRange_d;
                        memWr_q     <= inRange_d & selWe_d;
                        memAddr_q   <= selAddr_d;
                        memWdata_q  <= selWdata_d;
                        err_q       <= ~inRange_d;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    memEn_q <= 1'b0;
                    memWr_q <= 1'b0;
                    p0Ack_q <= ~winner_q;
                    p1Ack_q <= winner_q;
                    state_q <= RESP;
                end
                RESP: begin
                    p0Ack_q <= 1'b0;
                    p1Ack_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = memEn_q;
    assign bus.mem_wr    = memWr_q;
    assign bus.mem_addr  = memAddr_q;
    assign bus.mem_wdata = memWdata_q;

    // Read data is passed straight from the RAM output while the ack is up.
    assign bus.p0_ack   = p0Ack_q;
    assign bus.p0_err   = p0Ack_q & err_q;
    assign bus.p0_rdata = (p0Ack_q && !err_q) ? bus.mem_rdata : '0;
    assign bus.p1_ack   = p1Ack_q;
    assign bus.p1_err   = p1Ack_q & err_q;
    assign bus.p1_rdata = (p1Ack_q && !err_q) ? bus.mem_rdata : '0;
    assign bus.p0_stall = bus.p0_req & ~p0Ack_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios plus random accesses,
// compared against a transaction-level model of memory contents and round-robin order.
module tb_data_mem_arbiter;

    localparam int DW = 64;
    localparam int AW = 64;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    data_mem_arbiter_if #(.DATA_BITS(DW), .ADDR_BITS(AW)) bus ();

    data_mem_arbiter #(
        .DATA_BITS(DW), .ADDR_BITS(AW), .MEM_ADDR_BITS(10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] preloadWord(input logic [31:0] a);
        return {32'hDEAD_BEEF, a};
    endfunction

    // RAM model: registered read, write echoes the written word.
    logic [63:0] ram     [0:1023];
    bit          written [0:1023];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_wr) begin
                ram[bus.mem_addr[9:0]]     <= bus.mem_wdata;
                written[bus.mem_addr[9:0]] <= 1'b1;
                bus.mem_rdata              <= bus.mem_wdata;
            end else begin
                bus.mem_rdata <= written[bus.mem_addr[9:0]] ? ram[bus.mem_addr[9:0]]
                                                            : preloadWord({22'd0, bus.mem_addr[9:0]});
            end
        end
    end

    // Reference model: expected memory contents and round-robin history.
    logic [63:0] refMem [0:1023];
    bit          refLast;

    task automatic modelAccess(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                               output bit expErr, output logic [63:0] expData);
        if ((addr >> 10) != 64'd0) begin
            expErr  = 1'b1;
            expData = 64'd0;
        end else if (we) begin
            refMem[addr[9:0]] = wdata;
            expErr  = 1'b0;
            expData = wdata;
        end else begin
            expErr  = 1'b0;
            expData = refMem[addr[9:0]];
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drivePort(input bit port, input bit req, input bit we,
                             input logic [63:0] addr, input logic [63:0] wdata);
        if (port) begin
            bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
        end else begin
            bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
        end
    endtask

    task automatic dropReq(input bit port);
        if (port) bus.p1_req = 1'b0;
        else      bus.p0_req = 1'b0;
    endtask

    // One uncontended access on one port, with latency/strobe/stall accounting.
    task automatic applyStimulus(input bit port, input bit we, input logic [63:0] addr,
                                 input logic [63:0] wdata, input string name);
        bit          expErr, gotErr, otherAck, inRange;
        logic [63:0] expData, gotData, enAddr;
        int          ackTick, stallCnt, enCnt, wrCnt;
        ackTick = 0; enCnt = 0; wrCnt = 0; otherAck = 1'b0;
        gotErr = 1'b0; gotData = '0; enAddr = '0;
        inRange = ((addr >> 10) == 64'd0);
        @(negedge clk);
        drivePort(port, 1'b1, we, addr, wdata);
        #1;
        stallCnt = bus.p0_stall ? 1 : 0;
        for (int t = 1; t <= 8 && ackTick == 0; t++) begin
            @(negedge clk);
            if (bus.mem_en) begin enCnt++; enAddr = bus.mem_addr; end
            if (bus.mem_wr) wrCnt++;
            if (bus.p0_stall) stallCnt++;
            if (port ? bus.p0_ack : bus.p1_ack) otherAck = 1'b1;
            if (port ? bus.p1_ack : bus.p0_ack) begin
                ackTick = t;
                gotErr  = port ? bus.p1_err : bus.p0_err;
                gotData = port ? bus.p1_rdata : bus.p0_rdata;
            end
        end
        dropReq(port);
        modelAccess(we, addr, wdata, expErr, expData);
        refLast = port;
        checkOutput({name, ".latency"}, 64'(ackTick), 64'd2);
        checkOutput({name, ".err"}, 64'(gotErr), 64'(expErr));
        checkOutput({name, ".rdata"}, gotData, expData);
        checkOutput({name, ".memEnCycles"}, 64'(enCnt), inRange ? 64'd1 : 64'd0);
        checkOutput({name, ".memWrCycles"}, 64'(wrCnt), (inRange && we) ? 64'd1 : 64'd0);
        if (inRange) checkOutput({name, ".memAddr"}, enAddr, addr);
        checkOutput({name, ".stallCycles"}, 64'(stallCnt), port ? 64'd0 : 64'd2);
        checkOutput({name, ".otherAck"}, 64'(otherAck), 64'd0);
        @(negedge clk);
        checkOutput({name, ".ackPulse"}, 64'(port ? bus.p1_ack : bus.p0_ack), 64'd0);
    endtask

    // Both ports request in the same cycle; each drops its req once acked.
    task automatic applyPair(input bit we0, input logic [63:0] a0, input logic [63:0] d0,
                             input bit we1, input logic [63:0] a1, input logic [63:0] d1,
                             input string name);
        bit          firstPort, bothHigh;
        bit          expErr [2];
        logic [63:0] expData [2];
        bit          gotErr [2];
        logic [63:0] gotData [2];
        int          tick [2];
        tick[0] = 0; tick[1] = 0; bothHigh = 1'b0;
        gotErr[0] = 1'b0; gotErr[1] = 1'b0; gotData[0] = '0; gotData[1] = '0;
        firstPort = ~refLast;
        if (firstPort == 1'b0) begin
            modelAccess(we0, a0, d0, expErr[0], expData[0]);
            modelAccess(we1, a1, d1, expErr[1], expData[1]);
        end else begin
            modelAccess(we1, a1, d1, expErr[1], expData[1]);
            modelAccess(we0, a0, d0, expErr[0], expData[0]);
        end
        refLast = ~firstPort;
        @(negedge clk);
        drivePort(1'b0, 1'b1, we0, a0, d0);
        drivePort(1'b1, 1'b1, we1, a1, d1);
        for (int t = 1; t <= 12 && (tick[0] == 0 || tick[1] == 0); t++) begin
            @(negedge clk);
            if (bus.p0_ack && bus.p1_ack) bothHigh = 1'b1;
            if (bus.p0_ack && tick[0] == 0) begin
                tick[0] = t; gotErr[0] = bus.p0_err; gotData[0] = bus.p0_rdata; dropReq(1'b0);
            end
            if (bus.p1_ack && tick[1] == 0) begin
                tick[1] = t; gotErr[1] = bus.p1_err; gotData[1] = bus.p1_rdata; dropReq(1'b1);
            end
        end
        dropReq(1'b0);
        dropReq(1'b1);
        checkOutput({name, ".firstTick"}, 64'(tick[firstPort]), 64'd2);
        checkOutput({name, ".secondTick"}, 64'(tick[~firstPort]), 64'd5);
        checkOutput({name, ".bothAcks"}, 64'(bothHigh), 64'd0);
        for (int p = 0; p < 2; p++) begin
            checkOutput($sformatf("%s.p%0d.err", name, p), 64'(gotErr[p]), 64'(expErr[p]));
            checkOutput($sformatf("%s.p%0d.rdata", name, p), gotData[p], expData[p]);
        end
        @(negedge clk);
    endtask

    function automatic logic [63:0] randAddr();
        logic [63:0] a;
        a = 64'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) a = a | (64'd1 << $urandom_range(10, 63));
        return a;
    endfunction

    initial begin
        bit          seenAck, bothHigh, expPort, ePort, eErr;
        logic [63:0] eData, gData;
        int          ackCount, lastTick;

        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 1024; i++) refMem[i] = preloadWord(32'(i));
        refLast = 1'b1;
        rst_n = 1'b0;
        drivePort(1'b0, 1'b0, 1'b0, '0, '0);
        drivePort(1'b1, 1'b0, 1'b0, '0, '0);
        $display("[TB] starting data_mem_arbiter bench");

        repeat (3) @(negedge clk);
        checkOutput("reset.p0_ack", 64'(bus.p0_ack), 64'd0);
        checkOutput("reset.p1_ack", 64'(bus.p1_ack), 64'd0);
        checkOutput("reset.errs", 64'({bus.p0_err, bus.p1_err}), 64'd0);
        checkOutput("reset.p0_rdata", bus.p0_rdata, 64'd0);
        checkOutput("reset.p1_rdata", bus.p1_rdata, 64'd0);
        checkOutput("reset.mem_en", 64'({bus.mem_en, bus.mem_wr}), 64'd0);
        checkOutput("reset.mem_addr", bus.mem_addr, 64'd0);
        checkOutput("reset.mem_wdata", bus.mem_wdata, 64'd0);
        rst_n = 1'b1;

        // Both ports keep requesting out of reset: expect strict alternation every 3 cycles.
        @(negedge clk);
        drivePort(1'b0, 1'b1, 1'b0, 64'd7, '0);
        drivePort(1'b1, 1'b1, 1'b0, 64'd8, '0);
        ackCount = 0; lastTick = 0; bothHigh = 1'b0;
        for (int t = 1; t <= 14; t++) begin
            @(negedge clk);
            if (bus.p0_ack && bus.p1_ack) bothHigh = 1'b1;
            if (bus.p0_ack || bus.p1_ack) begin
                expPort = ~refLast;
                ePort   = bus.p1_ack;
                gData   = ePort ? bus.p1_rdata : bus.p0_rdata;
                modelAccess(1'b0, expPort ? 64'd8 : 64'd7, '0, eErr, eData);
                refLast = expPort;
                checkOutput($sformatf("alt.grant%0d.port", ackCount), 64'(ePort), 64'(expPort));
                checkOutput($sformatf("alt.grant%0d.gap", ackCount), 64'(t - lastTick),
                            (ackCount == 0) ? 64'd2 : 64'd3);
                checkOutput($sformatf("alt.grant%0d.rdata", ackCount), gData, eData);
                ackCount++;
                lastTick = t;
                if (ackCount == 4) begin
                    dropReq(1'b0);
                    dropReq(1'b1);
                end
            end
        end
        dropReq(1'b0);
        dropReq(1'b1);
        checkOutput("alt.ackCount", 64'(ackCount), 64'd4);
        checkOutput("alt.bothAcks", 64'(bothHigh), 64'd0);

        applyStimulus(1'b0, 1'b0, 64'd5, '0, "p0read5");
        applyStimulus(1'b1, 1'b1, 64'd10, 64'h1234, "p1write10");
        applyStimulus(1'b1, 1'b0, 64'd10, '0, "p1read10");

        // Out-of-range grant still advances round-robin, so the next contention goes to p1.
        applyStimulus(1'b0, 1'b0, 64'd1024, '0, "p0oor");
        applyPair(1'b0, 64'd1, '0, 1'b0, 64'd2, '0, "afterOor");

        // Reset during ISSUE of a p1 write abandons it without an ack or a RAM write.
        @(negedge clk);
        drivePort(1'b1, 1'b1, 1'b1, 64'd20, 64'hBAD0_BAD0_BAD0_BAD0);
        @(negedge clk);
        checkOutput("rstMid.enBefore", 64'(bus.mem_en), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstMid.mem_en", 64'(bus.mem_en), 64'd0);
        checkOutput("rstMid.mem_wr", 64'(bus.mem_wr), 64'd0);
        seenAck = bus.p1_ack;
        dropReq(1'b1);
        repeat (2) begin
            @(negedge clk);
            if (bus.p1_ack) seenAck = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.p1_ack) seenAck = 1'b1;
        end
        checkOutput("rstMid.noAck", 64'(seenAck), 64'd0);
        refLast = 1'b1;
        applyStimulus(1'b0, 1'b0, 64'd3, '0, "postRstRead3");
        applyStimulus(1'b1, 1'b0, 64'd20, '0, "postRstRead20");

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0: applyStimulus(1'b0, 1'($urandom_range(0, 1)), randAddr(),
                                 {$urandom, $urandom}, $sformatf("rnd%0d", i));
                1: applyStimulus(1'b1, 1'($urandom_range(0, 1)), randAddr(),
                                 {$urandom, $urandom}, $sformatf("rnd%0d", i));
                default: applyPair(1'($urandom_range(0, 1)), randAddr(), {$urandom, $urandom},
                                   1'($urandom_range(0, 1)), randAddr(), {$urandom, $urandom},
                                   $sformatf("rnd%0d", i));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
